// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the iterative arithmetic units: default operand
// width and the controller state encoding.
package shift_add_mult_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/shift_add_mult_ripple_adder.sv
// Parameterized combinational ripple-carry adder built from per-bit
// full-adder cells (sum = a^b^c, carry = majority(a, b, c)).
module ripple_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0] c;

   // Ripple the carry from bit 0 upward through a chain of full adders.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         s[i]     = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
   end

   assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier. Accepts an operand pair in
// IDLE, performs WIDTH add/shift steps in RUN, and holds the 2*WIDTH-bit
// product in DONE until the consumer takes it.
module shift_add_mult
   import shift_add_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int               CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   mult_state_t      state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] mq;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic             carry;

   // Partial-product selection: add the multiplicand only when the current
   // multiplier LSB is set.
   always_comb begin
      addend = mq[0] ? mcand : '0;
   end

   ripple_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (acc_hi),
      .b    (addend),
      .cin  (1'b0),
      .s    (sum),
      .cout (carry)
   );

   // Controller and datapath: load on accept, one add/shift per RUN cycle,
   // hold the result in DONE until taken; the unused encoding falls to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         acc_hi <= '0;
         mq     <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= a;
                  mq     <= b;
                  acc_hi <= '0;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               // Carry enters the MSB so the full product range stays exact.
               {acc_hi, mq} <= {carry, sum, mq[WIDTH-1:1]};
               cnt          <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   // Gated so that partial accumulator contents never appear on the output.
   assign product   = out_valid ? {acc_hi, mq} : '0;

endmodule
